// File: rtl/wrapped_instrumented_adder_brent_block_pkg.sv
// Shared constants for the instrumented Brent-Kung adder wrapper:
// register map, control-word bit positions and reset values.
package wrapped_instrumented_adder_brent_block_pkg;

    localparam int WIDTH = 32;

    typedef logic [WIDTH-1:0] word_t;

    localparam logic [2:0] ADDR_A_INPUT = 3'd0;
    localparam logic [2:0] ADDR_B_INPUT = 3'd1;
    localparam logic [2:0] ADDR_EXT_B   = 3'd2;
    localparam logic [2:0] ADDR_RING_B  = 3'd3;
    localparam logic [2:0] ADDR_S_OUT_B = 3'd4;

    localparam int CTRL_WR      = 4;
    localparam int CTRL_RING_EN = 5;
    localparam int CTRL_CLR     = 6;
    localparam int OENB_WR      = 4;

    localparam word_t RST_A_INPUT = 32'h0000_0000;
    localparam word_t RST_B_INPUT = 32'h0000_0000;
    localparam word_t RST_EXT_B   = 32'h0000_0000;
    localparam word_t RST_RING_B  = 32'h0000_0000;
    localparam word_t RST_S_OUT_B = 32'h01FF_FFFF;

endpackage

// File: rtl/wrapped_instrumented_adder_brent_block_instrumented_adder.sv
// Operand muxing, 32-bit Brent-Kung prefix adder, feedback selection and
// the chain_out flop that closes the ring oscillator loop.
module instrumented_adder
    import wrapped_instrumented_adder_brent_block_pkg::*;
(
    input  logic  wb_clk_i,
    input  logic  rst_n,
    input  logic  ring_en,
    input  word_t a_input,
    input  word_t b_input,
    input  word_t ext_b,
    input  word_t ring_b,
    input  word_t s_out_b,
    output word_t sum,
    output logic  cout,
    output logic  chain_out,
    output logic  chain_rise
);

    word_t a_eff;
    word_t g_pre;
    word_t p_pre;
    logic  fb;

    assign a_eff = (~ext_b & a_input) | (~ring_b & {WIDTH{chain_out}});

    // Up-sweep builds block prefixes at power-of-two boundaries; down-sweep
    // fills in the remaining positions. g_pre[i] ends as carry out of bit i.
    always_comb begin
        g_pre = a_eff & b_input;
        p_pre = a_eff ^ b_input;
        for (int l = 0; l < 5; l++) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (((i + 1) % (2 ** (l + 1))) == 0) begin
                    g_pre[i] = g_pre[i] | (p_pre[i] & g_pre[i - 2 ** l]);
                    p_pre[i] = p_pre[i] & p_pre[i - 2 ** l];
                end
            end
        end
        for (int l = 3; l >= 0; l--) begin
            for (int i = 0; i < WIDTH; i++) begin
                if ((((i + 1) % (2 ** (l + 1))) == 2 ** l) && (i >= 2 ** (l + 1))) begin
                    g_pre[i] = g_pre[i] | (p_pre[i] & g_pre[i - 2 ** l]);
                    p_pre[i] = p_pre[i] & p_pre[i - 2 ** l];
                end
            end
        end
    end

    assign sum  = (a_eff ^ b_input) ^ {g_pre[WIDTH-2:0], 1'b0};
    assign cout = g_pre[WIDTH-1];
    assign fb   = |(sum & ~s_out_b);

    assign chain_rise = ring_en & ~chain_out & ~fb;

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            chain_out <= 1'b0;
        end else if (ring_en) begin
            chain_out <= ~fb;
        end
    end

endmodule

// File: rtl/wrapped_instrumented_adder_brent_block.sv
// Wrapper: logic-analyser register file, cycle/edge counters, LA/IO mapping
// and project-select gating around the instrumented adder.
module wrapped_instrumented_adder_brent_block
    import wrapped_instrumented_adder_brent_block_pkg::*;
(
    input  logic        wb_clk_i,
    input  logic        rst_n,
    input  logic        active,
    input  logic [31:0] la1_data_in,
    output logic [31:0] la1_data_out,
    input  logic [31:0] la1_oenb,
    input  logic [31:0] la2_data_in,
    output logic [31:0] la2_data_out,
    input  logic [31:0] la2_oenb,
    input  logic [31:0] la3_data_in,
    output logic [31:0] la3_data_out,
    input  logic [31:0] la3_oenb,
    input  logic [37:0] io_in,
    output logic [37:0] io_out,
    output logic [37:0] io_oeb
);

    word_t a_input, b_input, ext_b, ring_b, s_out_b;
    word_t cycle_cnt, edge_cnt;
    word_t sum;
    logic  cout, chain_out, chain_rise;
    logic  wr_en, ring_en, cnt_clr;
    logic  unused_inputs;

    assign wr_en   = la1_data_in[CTRL_WR] & ~la1_oenb[OENB_WR];
    assign ring_en = la1_data_in[CTRL_RING_EN];
    assign cnt_clr = la1_data_in[CTRL_CLR];

    assign unused_inputs = ^{la1_data_in[31:7], la1_data_in[3], la1_oenb[31:5],
                             la1_oenb[3:0], la2_oenb, la3_data_in, la3_oenb, io_in};

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            a_input <= RST_A_INPUT;
            b_input <= RST_B_INPUT;
            ext_b   <= RST_EXT_B;
            ring_b  <= RST_RING_B;
            s_out_b <= RST_S_OUT_B;
        end else if (wr_en) begin
            case (la1_data_in[2:0])
                ADDR_A_INPUT: a_input <= la2_data_in;
                ADDR_B_INPUT: b_input <= la2_data_in;
                ADDR_EXT_B:   ext_b   <= la2_data_in;
                ADDR_RING_B:  ring_b  <= la2_data_in;
                ADDR_S_OUT_B: s_out_b <= la2_data_in;
                default: ;
            endcase
        end
    end

    // Clear wins over increment; both counters wrap naturally at 2^32.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
            edge_cnt  <= '0;
        end else if (cnt_clr) begin
            cycle_cnt <= '0;
            edge_cnt  <= '0;
        end else begin
            if (ring_en)    cycle_cnt <= cycle_cnt + 32'd1;
            if (chain_rise) edge_cnt  <= edge_cnt + 32'd1;
        end
    end

    instrumented_adder u_adder (
        .wb_clk_i   (wb_clk_i),
        .rst_n      (rst_n),
        .ring_en    (ring_en),
        .a_input    (a_input),
        .b_input    (b_input),
        .ext_b      (ext_b),
        .ring_b     (ring_b),
        .s_out_b    (s_out_b),
        .sum        (sum),
        .cout       (cout),
        .chain_out  (chain_out),
        .chain_rise (chain_rise)
    );

    assign la1_data_out = active ? cycle_cnt : 32'd0;
    assign la2_data_out = active ? sum       : 32'd0;
    assign la3_data_out = active ? edge_cnt  : 32'd0;
    assign io_out       = active ? {36'd0, cout, chain_out} : 38'd0;
    assign io_oeb       = active ? 38'd0 : {38{1'b1}};

endmodule

// File: tb/tb_wrapped_instrumented_adder_brent_block.sv
// Directed bench for the instrumented Brent-Kung adder wrapper.
module tb_wrapped_instrumented_adder_brent_block;

    logic        wb_clk_i = 1'b0;
    logic        rst_n;
    logic        active;
    logic [31:0] la1_data_in, la1_oenb, la2_data_in, la2_oenb, la3_data_in, la3_oenb;
    logic [31:0] la1_data_out, la2_data_out, la3_data_out;
    logic [37:0] io_in, io_out, io_oeb;

    int checks = 0;
    int failures = 0;

    always #5 wb_clk_i = ~wb_clk_i;

    wrapped_instrumented_adder_brent_block dut (
        .wb_clk_i     (wb_clk_i),
        .rst_n        (rst_n),
        .active       (active),
        .la1_data_in  (la1_data_in),
        .la1_data_out (la1_data_out),
        .la1_oenb     (la1_oenb),
        .la2_data_in  (la2_data_in),
        .la2_data_out (la2_data_out),
        .la2_oenb     (la2_oenb),
        .la3_data_in  (la3_data_in),
        .la3_data_out (la3_data_out),
        .la3_oenb     (la3_oenb),
        .io_in        (io_in),
        .io_out       (io_out),
        .io_oeb       (io_oeb)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; the write lands on the next rising edge.
    task automatic wr(input logic [2:0] addr, input logic [31:0] d);
        la1_data_in = 32'h10 | {29'd0, addr};
        la2_data_in = d;
        @(negedge wb_clk_i);
        la1_data_in = 32'h0;
    endtask

    initial begin
        rst_n = 1'b0; active = 1'b1;
        la1_data_in = 0; la1_oenb = 0; la2_data_in = 0; la2_oenb = 0;
        la3_data_in = 0; la3_oenb = 0; io_in = 0;
        #1;
        check("rst_la1", la1_data_out, 0);
        check("rst_la2", la2_data_out, 0);
        check("rst_io_out", io_out, 0);
        check("rst_io_oeb", io_oeb, 0);
        @(negedge wb_clk_i); rst_n = 1'b1;
        @(negedge wb_clk_i);

        wr(3'd0, 32'h0000_0005); wr(3'd1, 32'h0000_0003); wr(3'd3, 32'hFFFF_FFFF);
        check("add_sum", la2_data_out, 32'h0000_0008);
        check("add_cout", io_out[1], 1'b0);

        wr(3'd0, 32'hFFFF_FFFF); wr(3'd1, 32'h0000_0001);
        check("wrap_sum", la2_data_out, 32'h0000_0000);
        check("wrap_cout", io_out[1], 1'b1);

        wr(3'd0, 32'h1234_5678); wr(3'd1, 32'h0FED_CBA9);
        check("mix_sum", la2_data_out, 32'h2222_2221);
        check("mix_cout", io_out[1], 1'b0);

        wr(3'd2, 32'hFFFF_0000); wr(3'd0, 32'hFFFF_FFFF); wr(3'd1, 32'h0000_0000);
        check("extmask_sum", la2_data_out, 32'h0000_FFFF);

        wr(3'd5, 32'hDEAD_BEEF);
        check("addr5_ignored", la2_data_out, 32'h0000_FFFF);

        // Blocked write: oenb bit 4 high
        la1_oenb = 32'h10;
        wr(3'd1, 32'h0000_0001);
        la1_oenb = 32'h0;
        check("oenb_block", la2_data_out, 32'h0000_FFFF);

        wr(3'd0, 32'h0); wr(3'd1, 32'h0); wr(3'd2, 32'hFFFF_FFFE);
        wr(3'd3, 32'hFFFF_FFFE); wr(3'd4, 32'hFFFF_FFFE);
        check("ring_setup_sum", la2_data_out, 32'h0);

        la1_data_in = 32'h20;
        @(negedge wb_clk_i);
        check("ring_first_chain", io_out[0], 1'b1);
        repeat (9) @(negedge wb_clk_i);
        la1_data_in = 32'h0;
        check("ring_cycles", la1_data_out, 32'd10);
        check("ring_edges", la3_data_out, 32'd5);
        check("ring_chain_end", io_out[0], 1'b0);

        active = 1'b0; #1;
        check("inact_la1", la1_data_out, 0);
        check("inact_la2", la2_data_out, 0);
        check("inact_la3", la3_data_out, 0);
        check("inact_io_out", io_out, 0);
        check("inact_io_oeb", io_oeb, 38'h3F_FFFF_FFFF);
        active = 1'b1; #1;
        check("react_la1", la1_data_out, 32'd10);
        check("react_la3", la3_data_out, 32'd5);
        check("react_io_oeb", io_oeb, 0);
        @(negedge wb_clk_i);

        la1_data_in = 32'h60;
        @(negedge wb_clk_i);
        la1_data_in = 32'h20;
        check("clr_cycles", la1_data_out, 0);
        check("clr_edges", la3_data_out, 0);
        @(negedge wb_clk_i);
        check("post_clr_cycles", la1_data_out, 32'd1);
        check("post_clr_edges", la3_data_out, 32'd0);
        @(negedge wb_clk_i);
        la1_data_in = 32'h0;
        check("post_clr2_edges", la3_data_out, 32'd1);
        check("post_clr2_chain", io_out[0], 1'b1);

        // Write ring_b and enable together: old ring_b must drive the update
        la1_data_in = 32'h20 | 32'h10 | 32'h3;
        la2_data_in = 32'hFFFF_FFFF;
        @(negedge wb_clk_i);
        la1_data_in = 32'h0;
        check("wr_en_chain", io_out[0], 1'b0);
        check("wr_en_cycles", la1_data_out, 32'd3);

        #2 rst_n = 1'b0;
        #1;
        check("async_rst_la1", la1_data_out, 0);
        check("async_rst_la3", la3_data_out, 0);
        check("async_rst_io", io_out, 0);
        @(negedge wb_clk_i); rst_n = 1'b1;
        @(negedge wb_clk_i);

        // Default s_output_bit_b selects only bits 31:25 for feedback
        wr(3'd0, 32'h0100_0000);
        check("rst_sel_sum", la2_data_out, 32'h0100_0000);
        la1_data_in = 32'h20;
        @(negedge wb_clk_i);
        la1_data_in = 32'h0;
        check("rst_sel_chain", io_out[0], 1'b1);
        check("rst_sel_edges", la3_data_out, 32'd1);
        check("ring_operand_sum", la2_data_out, 32'hFFFF_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wrapped_instrumented_adder_brent_block.md
WRAPPED_INSTRUMENTED_ADDER_BRENT_BLOCK -- requirements
Module: wrapped_instrumented_adder_brent

Interface
REQ-001 SHALL have wb_clk_i, input, 1: sole clock; all state updates on rising edge.
REQ-002 SHALL have rst_n, input, 1: asynchronous active-low reset.
REQ-003 SHALL have active, input, 1: project select; when 0, all outputs take their inactive values.
REQ-004 SHALL have la1_data_in, input, 32: control word ([2:0] reg addr, [4] write strobe, [5] ring enable, [6] counter clear).
REQ-005 SHALL have la1_data_out, output, 32: clock-cycle counter while ring enabled.
REQ-006 SHALL have la1_oenb, input, 32: bit 4 must be 0 for a write to be accepted.
REQ-007 SHALL have la2_data_in, input, 32: write data.
REQ-008 SHALL have la2_data_out, output, 32: adder sum[31:0].
REQ-009 SHALL have la2_oenb and la3_oenb, input, 32 each: unused.
REQ-010 SHALL have la3_data_in, input, 32: unused.
REQ-011 SHALL have la3_data_out, output, 32: ring-edge counter.
REQ-012 SHALL have io_in, input, 38: unused.
REQ-013 SHALL have io_out, output, 38: [0] chain_out, [1] adder carry-out, others 0.
REQ-014 SHALL have io_oeb, output, 38: all 0 when active=1, all 1 when active=0.

Function
REQ-015 Registers: a_input, b_input, a_input_ext_bit_b, a_input_ring_bit_b, s_output_bit_b (32 bits each), addresses 0-4.
REQ-016 Write: when la1_data_in[4]=1 and la1_oenb[4]=0, the register at la1_data_in[2:0] SHALL load la2_data_in on the next edge; addresses 5-7 SHALL be ignored.
REQ-017 Effective operand per bit i: a_eff[i] = (~ext_b[i] & a_input[i]) | (~ring_b[i] & chain_out).
REQ-018 Adder: combinational 32-bit Brent-Kung prefix adder, {cout, sum} = a_eff + b_input; carry-in 0; results wrap modulo 2^32; cout on io_out[1].
REQ-019 Feedback: fb = OR of sum[i] over bits with s_output_bit_b[i]=0; fb=0 if no bit selected.
REQ-020 chain_out SHALL load ~fb on each edge while ring enable (la1_data_in[5]) is 1, and hold otherwise.
REQ-021 Ring-edge counter SHALL increment by 1 on each edge where chain_out goes 0->1 while enabled; it SHALL wrap at 2^32.
REQ-022 Cycle counter SHALL increment by 1 on each edge while enabled; it SHALL wrap at 2^32.
REQ-023 Counter clear (la1_data_in[6]=1) SHALL zero both counters on the next edge and take priority over increment.
REQ-024 A simultaneous write and enable SHALL use the old register values for that cycle's chain update.
REQ-025 When active=0, la*_data_out and io_out SHALL be 0; internal state SHALL continue to update.

Reset
REQ-026 While rst_n=0: a_input, b_input, ext_b, ring_b = 0; s_output_bit_b = 32'h01FF_FFFF; chain_out = 0; both counters = 0.
REQ-027 Reset assertion SHALL take effect immediately, independent of clock; release SHALL be synchronous to the following edge.

Structure
REQ-028 Shared package SHALL hold register address constants, control-bit indices and the reset values.
REQ-029 Sub-module instrumented_adder SHALL contain operand muxing, the Brent-Kung adder, feedback selection and the chain_out flop; the wrapper SHALL hold registers, counters, LA/IO mapping and active gating.

Verification
REQ-030 Reset: rst_n=0 mid-run with counters nonzero -> all outputs 0 at once, s_output_bit_b reads back 32'h01FF_FFFF in effect.
REQ-031 Add: write a=32'h0000_0005, b=32'h0000_0003, ext_b=32'hFFFF_FFFF... inverted: ext_b=0, ring_b=32'hFFFF_FFFF -> la2_data_out=8, io_out[1]=0.
REQ-032 Wrap: a=32'hFFFF_FFFF, b=1 -> sum=0, carry-out=1.
REQ-033 Ring: ext_b=32'hFFFF_FFFE, ring_b=32'hFFFF_FFFE, b=0, s_output_bit_b=32'hFFFF_FFFE, enable 10 cycles -> chain_out toggles each cycle, edge counter=5, cycle counter=10.
REQ-034 Clear + enable same cycle -> both counters 0 next cycle.
REQ-035 active=0 -> all data outputs 0, io_oeb=38'h3F_FFFF_FFFF; active=1 restores values unchanged.
